// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle for the multi-cycle ALU
interface alu_seq_if #(parameter int WIDTH = 8);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 zero;
    logic                 div_by_zero;
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, div_by_zero
    );
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, div_by_zero
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with shift-add multiply and restoring divide
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t               state, state_nx;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc, mcand, res;
    logic [WIDTH-1:0]     mplier, quo, rem, dvsr;
    logic                 dbz;
    logic                 accept;
    logic [WIDTH:0]       shifted, diff;
    assign accept  = bus.in_valid && (state == IDLE);
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvsr};
    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.result      = res;
    assign bus.zero        = (state == DONE) && (res == '0);
    assign bus.div_by_zero = (state == DONE) && dbz;
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // next-state: single-cycle ops and divide-by-zero skip straight to DONE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = !bus.op[1] ? DONE :
                                         !bus.op[0] ? MUL :
                                         (bus.b == '0) ? DONE : DIV;
            MUL:  if (cnt == '0) state_nx = DONE;
            DIV:  if (cnt == '0) state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
        endcase
    end
    // datapath: operand capture, one multiply/divide step per cycle, result load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            quo    <= '0;
            rem    <= '0;
            dvsr   <= '0;
            res    <= '0;
            dbz    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt    <= CW'(WIDTH);
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, bus.a};
                    mplier <= bus.b;
                    quo    <= bus.a;
                    rem    <= '0;
                    dvsr   <= bus.b;
                    if (!bus.op[1]) begin
                        res <= bus.op[0] ? {{WIDTH{1'b0}}, bus.a} - {{WIDTH{1'b0}}, bus.b}
                                         : {{WIDTH{1'b0}}, bus.a} + {{WIDTH{1'b0}}, bus.b};
                        dbz <= 1'b0;
                    end else if (bus.op[0] && bus.b == '0) begin
                        res <= {bus.a, {WIDTH{1'b1}}};
                        dbz <= 1'b1;
                    end
                end
                MUL: if (cnt == '0) begin
                    res <= acc;
                    dbz <= 1'b0;
                end else begin
                    acc    <= mplier[0] ? acc + mcand : acc;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                end
                DIV: if (cnt == '0) begin
                    res <= {rem, quo};
                    dbz <= 1'b0;
                end else begin
                    rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
                    cnt <= cnt - 1'b1;
                end
                DONE: ;
            endcase
        end
    end
endmodule
